// File: rtl/avg_sched_pkg.sv
// Shared defaults and FSM state type for the per-channel window averager.
package avg_sched_pkg;

  localparam int unsigned DEF_NCH = 4;
  localparam int unsigned DEF_W   = 8;
  localparam int unsigned SUM_W   = DEF_W + 2;
  localparam int unsigned DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUM    = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/avg4_diff_unit.sv
// Shared arithmetic: registered 4-sample sum, then average and |avg - last sample|.
module avg4_diff_unit
  import avg_sched_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [4*W-1:0] samples,
  output logic [W-1:0]   avg,
  output logic [W-1:0]   diff
);

  localparam int unsigned SW = W + 2;

  logic [SW-1:0] sum_c;
  logic [SW-1:0] sum_q;
  logic [W-1:0]  last_q;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < 4; k++) begin
      sum_c = sum_c + SW'(samples[k*W +: W]);
    end
  end

  // Sum and 4th sample are captured once per grant and held through RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      last_q <= '0;
    end else if (load) begin
      sum_q  <= sum_c;
      last_q <= samples[3*W +: W];
    end
  end

  always_comb begin
    avg  = W'(sum_q >> 2);
    diff = (avg >= last_q) ? (avg - last_q) : (last_q - avg);
  end

endmodule

// File: rtl/avg_channel_sched.sv
// Per-channel 4-sample buffers with a round-robin scheduler feeding one shared
// average/abs-diff unit; results leave through a valid/ready handshake.
module avg_channel_sched
  import avg_sched_pkg::*;
#(
  parameter int unsigned NCH = DEF_NCH,
  parameter int unsigned W   = DEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*W-1:0]         in_data,
  output logic [NCH-1:0]           in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCH)-1:0]   out_chan,
  output logic [W-1:0]             out_avg,
  output logic [W-1:0]             out_diff,
  output logic                     done
);

  localparam int unsigned CW    = $clog2(NCH);
  localparam int unsigned CNT_W = 3;

  state_t           state;
  logic [CW-1:0]    grant;
  logic [CW-1:0]    last_grant;
  logic [CW-1:0]    next_grant;
  logic             found;
  logic [CW-1:0]    idx;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   accept;
  logic [CNT_W-1:0] cnt [NCH];
  logic [W-1:0]     buf_q [NCH][DEPTH];
  logic [4*W-1:0]   sel;

  // A channel is full (pending) exactly when its count reaches 4.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      pending[c]  = cnt[c][2];
      in_ready[c] = ~cnt[c][2];
    end
    accept = in_valid & in_ready;
    done   = (state == IDLE) && (pending == '0);
  end

  // Round-robin search starting one past the last served channel.
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    idx        = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = last_grant + CW'(i);
      if (!found && pending[idx]) begin
        found      = 1'b1;
        next_grant = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (accept[c]) buf_q[c][cnt[c][1:0]] <= in_data[c*W +: W];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sel[k*W +: W] = buf_q[grant][k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CW'(NCH - 1);
      out_valid  <= 1'b0;
      out_chan   <= '0;
      for (int c = 0; c < NCH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (accept[c]) cnt[c] <= cnt[c] + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= SUM;
          end
        end
        SUM: begin
          out_valid <= 1'b1;
          out_chan  <= grant;
          state     <= RESULT;
        end
        RESULT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            cnt[grant] <= '0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  avg4_diff_unit #(.W(W)) u_unit (
    .clk     (clk),
    .rst     (rst),
    .load    (state == SUM),
    .samples (sel),
    .avg     (out_avg),
    .diff    (out_diff)
  );

endmodule

// File: tb/tb_avg_channel_sched.sv
// Directed self-checking bench for avg_channel_sched (NCH=4, W=8).
module tb_avg_channel_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0] in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_chan;
  logic [W-1:0]   out_avg;
  logic [W-1:0]   out_diff;
  logic           done;

  int n_cmp = 0;
  int n_err = 0;

  avg_channel_sched #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_avg   (out_avg),
    .out_diff  (out_diff),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One handshake cycle presenting value v on every channel in mask.
  task automatic push(input logic [NCH-1:0] mask, input logic [W-1:0] v);
    in_valid = mask;
    in_data  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) in_data[c*W +: W] = v;
    end
    step();
    in_valid = '0;
  endtask

  task automatic feed4(input logic [NCH-1:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    push(mask, a);
    push(mask, b);
    push(mask, c);
    push(mask, d);
  endtask

  // Waits (bounded) for out_valid, checks the result, then lets one edge pass.
  task automatic wait_result(input string tag, input int ch, input int avg, input int diff);
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_chan"},  32'(out_chan),  32'(ch));
    chk({tag, "_avg"},   32'(out_avg),   32'(avg));
    chk({tag, "_diff"},  32'(out_diff),  32'(diff));
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'hF);
    chk("rst_done",      32'(done),      32'd1);
    chk("rst_out_chan",  32'(out_chan),  32'd0);
    chk("rst_out_avg",   32'(out_avg),   32'd0);
    chk("rst_out_diff",  32'(out_diff),  32'd0);

    // Basic result and 2-cycle latency from the grant cycle
    feed4(4'b0001, 8'd10, 8'd20, 8'd30, 8'd40);
    chk("c0_grant_ready", 32'(in_ready[0]), 32'd0);
    chk("c0_grant_done",  32'(done),        32'd0);
    chk("c0_grant_ov",    32'(out_valid),   32'd0);
    step();
    chk("c0_sum_ov",      32'(out_valid),   32'd0);
    step();
    chk("c0_res_ov",      32'(out_valid),   32'd1);
    chk("c0_res_chan",    32'(out_chan),    32'd0);
    chk("c0_res_avg",     32'(out_avg),     32'd25);
    chk("c0_res_diff",    32'(out_diff),    32'd15);
    step();
    chk("c0_post_ov",     32'(out_valid),   32'd0);
    chk("c0_post_ready",  32'(in_ready),    32'hF);
    chk("c0_post_done",   32'(done),        32'd1);

    // Arithmetic corners
    feed4(4'b0010, 8'd255, 8'd255, 8'd255, 8'd255);
    wait_result("c1_max", 1, 255, 0);
    feed4(4'b0100, 8'd1, 8'd1, 8'd1, 8'd2);
    wait_result("c2_trunc", 2, 1, 1);
    feed4(4'b1000, 8'd0, 8'd0, 8'd0, 8'd8);
    wait_result("c3_diff", 3, 2, 6);

    // Round-robin fairness after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    feed4(4'b0101, 8'd8, 8'd8, 8'd8, 8'd8);
    wait_result("rr_a0", 0, 8, 0);
    wait_result("rr_a2", 2, 8, 0);
    feed4(4'b0101, 8'd3, 8'd5, 8'd7, 8'd9);
    wait_result("rr_b0", 0, 6, 3);
    wait_result("rr_b2", 2, 6, 3);

    // Backpressure: result held stable, other channel keeps filling
    out_ready = 1'b0;
    feed4(4'b0010, 8'd100, 8'd100, 8'd100, 8'd101);
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 4'b1000;
        in_data  = '0;
        in_data[31:24] = 8'(20 + i);
      end else begin
        in_valid = '0;
      end
      step();
      chk("bp_ov",    32'(out_valid),   32'd1);
      chk("bp_chan",  32'(out_chan),    32'd1);
      chk("bp_avg",   32'(out_avg),     32'd100);
      chk("bp_diff",  32'(out_diff),    32'd1);
      chk("bp_rdy1",  32'(in_ready[1]), 32'd0);
    end
    in_valid = '0;
    chk("bp_c3_full", 32'(in_ready[3]), 32'd0);
    out_ready = 1'b1;
    wait_result("bp_c1", 1, 100, 1);
    wait_result("bp_c3", 3, 21, 2);

    // Mid-operation reset discards partial buffer and in-flight result
    out_ready = 1'b0;
    feed4(4'b0010, 8'd9, 8'd9, 8'd9, 8'd9);
    push(4'b0001, 8'd7);
    push(4'b0001, 8'd7);
    push(4'b0001, 8'd7);
    chk("mr_pre_ov", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_ov",    32'(out_valid), 32'd0);
    chk("mr_ready", 32'(in_ready),  32'hF);
    chk("mr_done",  32'(done),      32'd1);
    out_ready = 1'b1;
    feed4(4'b0001, 8'd50, 8'd60, 8'd70, 8'd80);
    wait_result("mr_c0", 0, 65, 15);

    // Fifth sample on a full channel is refused
    feed4(4'b0001, 8'd1, 8'd2, 8'd3, 8'd4);
    chk("ov_ready_low", 32'(in_ready[0]), 32'd0);
    push(4'b0001, 8'd200);
    wait_result("ov_c0", 0, 2, 2);
    chk("ov_ready_back", 32'(in_ready[0]), 32'd1);
    chk("end_done",      32'(done),        32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
